// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops bytes from a FWFT FIFO and shifts out
// start, DBIT data bits (LSB first), optional parity and stop at 16x oversampling.
module uart_tx_engine #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            busy,
  output logic            tx_done_tick
);

  localparam int unsigned S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int unsigned SW    = $clog2(S_MAX);
  localparam int unsigned NW    = $clog2(DBIT);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  logic [2:0]      state, state_next;
  logic [SW-1:0]   s, s_next;
  logic [NW-1:0]   n, n_next;
  logic [DBIT-1:0] b, b_next;
  logic            p, p_next;
  logic            tx_next;

  // State, datapath and registered line/busy outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      p     <= 1'b0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      s     <= s_next;
      n     <= n_next;
      b     <= b_next;
      p     <= p_next;
      tx    <= tx_next;
      busy  <= (state_next != IDLE);
    end
  end

  // Next-state, datapath update and strobes
  always_comb begin
    state_next   = state;
    s_next       = s;
    n_next       = n;
    b_next       = b;
    p_next       = p;
    tx_next      = 1'b1;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty && !reset) begin
          fifo_rd    = 1'b1;
          b_next     = fifo_data;
          p_next     = (PARITY == 2) ? ~^fifo_data : ^fifo_data;
          s_next     = '0;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      DATA: begin
        tx_next = b[0];
        if (s_tick) begin
          if (s == SW'(15)) begin
            b_next = b >> 1;
            s_next = '0;
            if (n == NW'(DBIT - 1)) begin
              state_next = (PARITY != 0) ? PAR : STOP;
            end else begin
              n_next = n + NW'(1);
            end
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      PAR: begin
        tx_next = p;
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (s_tick) begin
          if (s == SW'(SB_TICK - 1)) begin
            tx_done_tick = 1'b1;
            state_next   = IDLE;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: three instances (no parity / even / odd with 2 stop bits)
// fed by queue FIFO models; a monitor decodes each frame against a scoreboard.
module tb_uart_tx_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_tick = 1'b0;
  int   tick_div = 0;

  logic       fempty [3] = '{1'b1, 1'b1, 1'b1};
  logic [7:0] fdata  [3] = '{8'h00, 8'h00, 8'h00};
  logic       rd_w [3];
  logic       tx_w [3];
  logic       busy_w [3];
  logic       done_w [3];

  logic [7:0] fq    [3][$];
  logic [7:0] pend  [3][$];
  logic [7:0] exp_q [3][$];

  int tests = 0;
  int fails = 0;
  int pops  [3] = '{0, 0, 0};
  int loads [3] = '{0, 0, 0};
  int tcnt  [3] = '{0, 0, 0};
  bit active [3] = '{0, 0, 0};
  bit stable [3];
  bit stop_ok [3];
  bit expect_pop [3] = '{0, 0, 0};
  logic first [3];
  logic [10:0] mid [3];
  logic [7:0] cur [3];

  always #5 clk = ~clk;

  // Baud x16 enable: one clk pulse every 4 clk
  always @(posedge clk) begin
    tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
    s_tick   <= (tick_div == 3);
  end

  uart_tx_engine #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fempty[0]), .fifo_data(fdata[0]),
    .fifo_rd(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done_tick(done_w[0]));
  uart_tx_engine #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fempty[1]), .fifo_data(fdata[1]),
    .fifo_rd(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done_tick(done_w[1]));
  uart_tx_engine #(.DBIT(8), .SB_TICK(32), .PARITY(2)) u2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fempty[2]), .fifo_data(fdata[2]),
    .fifo_rd(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done_tick(done_w[2]));

  function automatic int flen(input int i);
    return 16 * (9 + ((i != 0) ? 1 : 0)) + ((i == 2) ? 32 : 16);
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[u%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] v);
    pend[i].push_back(v);
    exp_q[i].push_back(v);
    loads[i]++;
  endtask

  // FWFT FIFO models: pop on fifo_rd, then admit newly pushed words
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_w[i] && fq[i].size() > 0) void'(fq[i].pop_front());
      while (pend[i].size() > 0) fq[i].push_back(pend[i].pop_front());
      fempty[i] <= (fq[i].size() == 0);
      fdata[i]  <= (fq[i].size() > 0) ? fq[i][0] : 8'h00;
    end
  end

  // Monitor: decode line at ticks 2/8/16 of each bit, check against scoreboard
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        active[i]     = 1'b0;
        expect_pop[i] = 1'b0;
      end else begin
        if (expect_pop[i]) begin
          check("b2b_pop_rd_busy", i, int'({rd_w[i], busy_w[i]}), 2);
          expect_pop[i] = 1'b0;
        end
        if (rd_w[i]) begin
          pops[i]++;
          check("rd_legal", i, int'(busy_w[i] | fempty[i]), 0);
        end
        if (!active[i] && busy_w[i]) begin
          active[i]  = 1'b1;
          tcnt[i]    = 0;
          stable[i]  = 1'b1;
          stop_ok[i] = 1'b1;
          mid[i]     = '0;
          if (exp_q[i].size() == 0) begin
            check("unexpected_frame", i, 1, 0);
            cur[i] = 8'h00;
          end else begin
            cur[i] = exp_q[i].pop_front();
          end
        end
        if (active[i]) begin
          int nb, j, k;
          nb = 9 + ((i != 0) ? 1 : 0);
          if (s_tick) begin
            tcnt[i]++;
            j = (tcnt[i] - 1) / 16;
            k = (tcnt[i] - 1) % 16 + 1;
            if (j < nb) begin
              if (k == 2) first[i] = tx_w[i];
              if (k == 8) begin
                mid[i][j] = tx_w[i];
                if (tx_w[i] !== first[i]) stable[i] = 1'b0;
              end
              if (k == 16 && tx_w[i] !== mid[i][j]) stable[i] = 1'b0;
            end else if (tx_w[i] !== 1'b1) begin
              stop_ok[i] = 1'b0;
            end
          end
          if (done_w[i]) begin
            check("done_on_tick", i, int'(s_tick), 1);
            check("frame_ticks", i, tcnt[i], flen(i));
            check("start_bit", i, int'(mid[i][0]), 0);
            check("data_bits", i, int'(mid[i][8:1]), int'(cur[i]));
            if (i != 0)
              check("parity_bit", i, int'(mid[i][9]), (i == 1) ? int'(^cur[i]) : int'(~^cur[i]));
            check("stop_high", i, int'(stop_ok[i]), 1);
            check("bit_stable", i, int'(stable[i]), 1);
            active[i] = 1'b0;
            if (!fempty[i]) expect_pop[i] = 1'b1;
          end else if (tcnt[i] > flen(i) + 16) begin
            check("frame_timeout", i, tcnt[i], flen(i));
            active[i] = 1'b0;
          end
        end else if (done_w[i]) begin
          check("done_outside_frame", i, 1, 0);
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0 &&
          pend[0].size() == 0 && pend[1].size() == 0 && pend[2].size() == 0 &&
          !busy_w[0] && !busy_w[1] && !busy_w[2] &&
          !active[0] && !active[1] && !active[2]) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle", 0, int'(ok), 1);
  endtask

  task automatic wait_ticks(input int i, input int n);
    for (int c = 0; c < 4000 && tcnt[i] < n; c++) @(negedge clk);
    check("wait_ticks", i, int'(tcnt[i] >= n), 1);
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_tx", i, int'(tx_w[i]), 1);
      check("reset_busy", i, int'(busy_w[i]), 0);
      check("reset_rd", i, int'(rd_w[i]), 0);
    end
    reset = 1'b0;

    // Idle with empty FIFO while s_tick keeps running
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || rd_w[i] !== 1'b0 || done_w[i] !== 1'b0) bad++;
    end
    check("idle_quiet", 0, bad, 0);

    // Single frames: 0xA5 no parity; 0x07 even parity; 0x07 odd parity with 2 stop bits
    @(negedge clk);
    push(0, 8'hA5);
    push(1, 8'h07);
    push(2, 8'h07);
    wait_idle();

    // Back-to-back frames
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h55);
    wait_idle();

    // Reset during data bit 3 of 0x3C
    push(0, 8'h3C);
    wait_ticks(0, 72);
    reset = 1'b1;
    #1;
    check("abort_tx", 0, int'(tx_w[0]), 1);
    check("abort_busy", 0, int'(busy_w[0]), 0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || rd_w[0] !== 1'b0) bad++;
    end
    check("abort_quiet", 0, bad, 0);
    reset = 1'b0;
    push(0, 8'h81);
    wait_idle();

    // FIFO goes non-empty mid-frame
    push(0, 8'h12);
    push(2, 8'hC3);
    wait_ticks(0, 40);
    push(0, 8'h34);
    wait_idle();

    for (int i = 0; i < 3; i++) begin
      check("pop_count", i, pops[i], loads[i]);
      check("scoreboard_drained", i, exp_q[i].size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
